// File: rtl/md5_pkg.sv
// Shared MD5 datapath constants and digest type.
package md5_pkg;

  localparam int unsigned MD5_DIGEST_W = 128;
  localparam int unsigned MD5_CHUNK_W  = 32;

  typedef logic [MD5_DIGEST_W-1:0] md5_digest_t;

endpackage : md5_pkg

// File: rtl/md5_match_slice.sv
// One target slot: target (and optional mask) register, S1 chunk-equality
// and enable registers, and the registered per-slot S2 match bit.
// Optional feature: MD5_MATCH_MASK_EN adds a per-slot compare mask.
module md5_match_slice
  import md5_pkg::*;
#(
  parameter int unsigned WIDTH = MD5_DIGEST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_digest,
`ifdef MD5_MATCH_MASK_EN
  input  logic [WIDTH-1:0] cfg_mask,
`endif
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] in_digest,
  input  logic             s1_valid,
  output logic             match
);

  localparam int unsigned CHUNKS = WIDTH / MD5_CHUNK_W;

  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  diff;
  logic [CHUNKS-1:0] eq_q, eq_d;
  logic              en_q, en_d;
  logic              match_q, match_d;
`ifdef MD5_MATCH_MASK_EN
  logic [WIDTH-1:0]  mask_q, mask_d;
`endif

  // Next-state: config write, per-chunk compare against the current target
  always_comb begin
    target_d = target_q;
`ifdef MD5_MATCH_MASK_EN
    mask_d   = mask_q;
    diff     = (in_digest ^ target_q) & mask_q;
`else
    diff     = in_digest ^ target_q;
`endif
    if (cfg_we) begin
      target_d = cfg_digest;
`ifdef MD5_MATCH_MASK_EN
      mask_d   = cfg_mask;
`endif
    end
    for (int k = 0; k < int'(CHUNKS); k++) begin
      eq_d[k] = (diff[k*MD5_CHUNK_W +: MD5_CHUNK_W] == '0);
    end
    en_d    = cfg_en;
    match_d = s1_valid & en_q & (&eq_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q <= '0;
`ifdef MD5_MATCH_MASK_EN
      mask_q   <= '1;
`endif
      eq_q     <= '0;
      en_q     <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      target_q <= target_d;
`ifdef MD5_MATCH_MASK_EN
      mask_q   <= mask_d;
`endif
      eq_q     <= eq_d;
      en_q     <= en_d;
      match_q  <= match_d;
    end
  end

  assign match = match_q;

endmodule : md5_match_slice

// File: rtl/md5_match_unit.sv
// Multi-target digest matcher: two-stage compare pipeline, lowest-index
// priority, sticky first-hit capture and saturating match count.
// Optional feature: MD5_MATCH_MASK_EN (per-slot prefix mask via cfg_mask).
module md5_match_unit
  import md5_pkg::*;
#(
  parameter  int unsigned WIDTH   = MD5_DIGEST_W,
  parameter  int unsigned TARGETS = 4,
  parameter  int unsigned TAG_W   = 32,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W   = (TARGETS > 1) ? $clog2(TARGETS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]   cfg_digest,
`ifdef MD5_MATCH_MASK_EN
  input  logic [WIDTH-1:0]   cfg_mask,
`endif
  input  logic [TARGETS-1:0] cfg_en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_digest,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               clr,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [TAG_W-1:0]   hit_tag,
  output logic [CNT_W-1:0]   hit_count,
  output logic               hit_pulse
);

  logic [TARGETS-1:0] slot_we;
  logic [TARGETS-1:0] slot_match;

  logic               s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [TAG_W-1:0]   hit_tag_q, hit_tag_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               hit_pulse_q, hit_pulse_d;

  logic               any_match;
  logic [IDX_W-1:0]   first_idx;
  logic               base_hit;
  logic [CNT_W-1:0]   base_count;

  for (genvar i = 0; i < int'(TARGETS); i++) begin : g_slot
    assign slot_we[i] = cfg_we && (cfg_idx == IDX_W'(i));

    md5_match_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (slot_we[i]),
      .cfg_digest(cfg_digest),
`ifdef MD5_MATCH_MASK_EN
      .cfg_mask  (cfg_mask),
`endif
      .cfg_en    (cfg_en[i]),
      .in_digest (in_digest),
      .s1_valid  (s1_valid_q),
      .match     (slot_match[i])
    );
  end

  // Lowest-index priority encode over the S2 match bits
  always_comb begin
    first_idx = '0;
    for (int i = int'(TARGETS) - 1; i >= 0; i--) begin
      if (slot_match[i]) first_idx = IDX_W'(i);
    end
    any_match = s2_valid_q && (|slot_match);
  end

  // Pipeline tags plus capture; clr is applied first so a coincident match re-captures
  always_comb begin
    s1_valid_d  = in_valid;
    s1_tag_d    = in_tag;
    s2_valid_d  = s1_valid_q;
    s2_tag_d    = s1_tag_q;

    base_hit    = clr ? 1'b0 : hit_q;
    base_count  = clr ? '0 : hit_count_q;
    hit_d       = base_hit;
    hit_idx_d   = clr ? '0 : hit_idx_q;
    hit_tag_d   = clr ? '0 : hit_tag_q;
    hit_count_d = base_count;
    hit_pulse_d = 1'b0;

    if (any_match) begin
      hit_pulse_d = 1'b1;
      if (!base_hit) begin
        hit_d     = 1'b1;
        hit_idx_d = first_idx;
        hit_tag_d = s2_tag_q;
      end
      if (base_count != '1) hit_count_d = base_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      hit_tag_q   <= '0;
      hit_count_q <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      hit_tag_q   <= hit_tag_d;
      hit_count_q <= hit_count_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign hit_tag   = hit_tag_q;
  assign hit_count = hit_count_q;
  assign hit_pulse = hit_pulse_q;

endmodule : md5_match_unit

// File: tb/tb_md5_match_unit.sv
// Self-checking bench for md5_match_unit: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_md5_match_unit;
  import md5_pkg::*;

  localparam int unsigned W     = 128;
  localparam int unsigned T     = 4;
  localparam int unsigned TAG_W = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int          CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [W-1:0]     cfg_digest;
  logic [W-1:0]     cfg_mask;
  logic [T-1:0]     cfg_en;
  logic             in_valid;
  logic [W-1:0]     in_digest;
  logic [TAG_W-1:0] in_tag;
  logic             clr;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [TAG_W-1:0] hit_tag;
  logic [CNT_W-1:0] hit_count;
  logic             hit_pulse;

  md5_match_unit #(.WIDTH(W), .TARGETS(T), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_digest(cfg_digest),
`ifdef MD5_MATCH_MASK_EN
    .cfg_mask  (cfg_mask),
`endif
    .cfg_en    (cfg_en),
    .in_valid  (in_valid),
    .in_digest (in_digest),
    .in_tag    (in_tag),
    .clr       (clr),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_tag   (hit_tag),
    .hit_count (hit_count),
    .hit_pulse (hit_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: target table plus a two-entry queue of pending results
  logic [W-1:0]     tgt_m [T];
  logic [W-1:0]     msk_m [T];
  int               pend_idx [$];
  logic [TAG_W-1:0] pend_tag [$];
  bit               m_hit;
  int               m_idx;
  logic [TAG_W-1:0] m_tag;
  int               m_cnt;
  bit               m_pulse;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] DA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [W-1:0] DB = 128'h11112222333344445555666677778888;
  localparam logic [W-1:0] DC = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [W-1:0] DD = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [W-1:0] DE = 128'hFEEDFACECAFEBABE0BADF00DDEADC0DE;

  typedef struct {
    bit           clr_first;
    logic [T-1:0] en;
    logic [W-1:0] dig;
    logic [31:0]  tag;
    bit           e_pulse;
    bit           e_hit;
    int           e_idx;
    logic [31:0]  e_tag;
    int           e_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int find_match(input logic [W-1:0] d, input logic [T-1:0] en);
    for (int i = 0; i < int'(T); i++) begin
      if (en[i] && (((d ^ tgt_m[i]) & msk_m[i]) == '0)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(T); i++) begin
      tgt_m[i] = '0;
      msk_m[i] = '1;
    end
    pend_idx.delete();
    pend_tag.delete();
    pend_idx.push_back(-1); pend_tag.push_back('0);
    pend_idx.push_back(-1); pend_tag.push_back('0);
    m_hit = 0; m_idx = 0; m_tag = '0; m_cnt = 0; m_pulse = 0;
  endtask

  task automatic check_outputs(input string sfx);
    check({"hit", sfx},       128'(hit),       128'(m_hit));
    check({"hit_idx", sfx},   128'(hit_idx),   128'(m_idx));
    check({"hit_tag", sfx},   128'(hit_tag),   128'(m_tag));
    check({"hit_count", sfx}, 128'(hit_count), 128'(m_cnt));
    check({"hit_pulse", sfx}, 128'(hit_pulse), 128'(m_pulse));
  endtask

  // One clock: result enters the queue now, surfaces two edges later
  task automatic tick();
    int nidx;
    int oidx;
    logic [TAG_W-1:0] otag;
    nidx = in_valid ? find_match(in_digest, cfg_en) : -1;
    @(posedge clk);
    oidx = pend_idx.pop_front();
    otag = pend_tag.pop_front();
    m_pulse = 0;
    if (clr) begin
      m_hit = 0; m_idx = 0; m_tag = '0; m_cnt = 0;
    end
    if (oidx >= 0) begin
      m_pulse = 1;
      if (!m_hit) begin
        m_hit = 1; m_idx = oidx; m_tag = otag;
      end
      if (m_cnt < CMAX) m_cnt++;
    end
    pend_idx.push_back(nidx);
    pend_tag.push_back(in_tag);
    if (cfg_we) begin
      tgt_m[cfg_idx] = cfg_digest;
`ifdef MD5_MATCH_MASK_EN
      msk_m[cfg_idx] = cfg_mask;
`endif
    end
    #1;
    check_outputs("");
  endtask

  task automatic write_slot(input int idx, input logic [W-1:0] d, input logic [W-1:0] m);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_digest = d; cfg_mask = m;
    tick();
    cfg_we = 0;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic [31:0] tag);
    in_valid = 1; in_digest = d; in_tag = tag;
    tick();
    in_valid = 0;
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  initial begin
    rst = 0; cfg_we = 0; cfg_idx = '0; cfg_digest = '0; cfg_mask = '1;
    cfg_en = '0; in_valid = 0; in_digest = '0; in_tag = '0; clr = 0;
    model_reset();
    #12;
    check_outputs("_rst");
    @(negedge clk);
    rst = 1;

    write_slot(0, DA, '1);
    write_slot(1, DB, '1);
    write_slot(2, DC, '1);
    write_slot(3, DB, '1);

    vecs[0] = '{0, 4'b0001, DA,      32'h2A, 1, 1, 0, 32'h2A, 1};
    vecs[1] = '{1, 4'b1010, DB,      32'h11, 1, 1, 1, 32'h11, 1};
    vecs[2] = '{0, 4'b1010, DB,      32'h55, 1, 1, 1, 32'h11, 2};
    vecs[3] = '{1, 4'b1011, DC,      32'h33, 0, 0, 0, 32'h00, 0};
    vecs[4] = '{0, 4'b0100, DC,      32'h44, 1, 1, 2, 32'h44, 1};
    vecs[5] = '{0, 4'b1111, DD,      32'h66, 0, 1, 2, 32'h44, 1};
    vecs[6] = '{0, 4'b0001, DA ^ 1,  32'h99, 0, 1, 2, 32'h44, 1};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].clr_first) pulse_clr();
      cfg_en = vecs[v].en;
      feed(vecs[v].dig, vecs[v].tag);
      tick();
      tick();
      check("tbl_pulse", 128'(hit_pulse), 128'(vecs[v].e_pulse));
      check("tbl_hit",   128'(hit),       128'(vecs[v].e_hit));
      check("tbl_idx",   128'(hit_idx),   128'(vecs[v].e_idx));
      check("tbl_tag",   128'(hit_tag),   128'(vecs[v].e_tag));
      check("tbl_cnt",   128'(hit_count), 128'(vecs[v].e_cnt));
      tick();
    end

    // clr coinciding with a match in S2: clear then capture
    cfg_en = 4'b0001;
    feed(DA, 32'h77);
    tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr_cap_hit", 128'(hit),       128'(1));
    check("clr_cap_idx", 128'(hit_idx),   128'(0));
    check("clr_cap_tag", 128'(hit_tag),   128'(32'h77));
    check("clr_cap_cnt", 128'(hit_count), 128'(1));

    // 300 back-to-back matches saturate the counter
    in_valid = 1; in_digest = DA;
    for (int i = 0; i < 300; i++) begin
      in_tag = 32'(1000 + i);
      tick();
    end
    in_valid = 0;
    tick();
    tick();
    check("sat_cnt", 128'(hit_count), 128'(255));
    check("sat_tag", 128'(hit_tag),   128'(32'h77));

    // Target write while a digest is in flight
    pulse_clr();
    cfg_en = 4'b0001;
    cfg_we = 1; cfg_idx = '0; cfg_digest = DE; cfg_mask = '1;
    in_valid = 1; in_digest = DE; in_tag = 32'h100;
    tick();
    cfg_we = 0; in_tag = 32'h101;
    tick();
    in_valid = 0;
    tick();
    check("wr_old_pulse", 128'(hit_pulse), 128'(0));
    tick();
    check("wr_new_pulse", 128'(hit_pulse), 128'(1));
    check("wr_new_tag",   128'(hit_tag),   128'(32'h101));
    tick();

    // Asynchronous reset with a matching digest in flight
    feed(DE, 32'hAB);
    #2;
    rst = 0;
    #1;
    model_reset();
    check_outputs("_async_rst");
    @(negedge clk);
    rst = 1;
    tick();
    tick();
    check("rst_no_pulse", 128'(hit_pulse), 128'(0));
    cfg_en = 4'b0001;
    feed(DE, 32'h7);
    tick();
    tick();
    check("rst_tgt_pulse", 128'(hit_pulse), 128'(0));
    feed('0, 32'h5);
    tick();
    tick();
    check("rst_zero_pulse", 128'(hit_pulse), 128'(1));
    check("rst_zero_tag",   128'(hit_tag),   128'(32'h5));

    // Prefix mask on the top word only
    write_slot(0, {32'hDEADBEEF, 96'h111111111111111111111111}, {32'hFFFFFFFF, 96'h0});
    pulse_clr();
    feed({32'hDEADBEEF, 96'h222222222222222222222222}, 32'hB0);
    tick();
    tick();
`ifdef MD5_MATCH_MASK_EN
    check("mask_pulse", 128'(hit_pulse), 128'(1));
    check("mask_hit",   128'(hit),       128'(1));
`else
    check("mask_pulse", 128'(hit_pulse), 128'(0));
    check("mask_hit",   128'(hit),       128'(0));
`endif
    write_slot(0, DA, '1);

    // Randomized traffic from a small digest pool
    begin
      logic [W-1:0] pool [4];
      pool[0] = DA; pool[1] = DB; pool[2] = DC; pool[3] = DE;
      for (int c = 0; c < 600; c++) begin
        cfg_we = ($urandom_range(0, 7) == 0);
        cfg_idx = IDX_W'($urandom_range(0, T - 1));
        cfg_digest = pool[$urandom_range(0, 3)];
        cfg_mask = ($urandom_range(0, 3) == 0) ? {32'hFFFFFFFF, 96'h0} : '1;
        cfg_en = T'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0)
          in_digest = {$urandom, $urandom, $urandom, $urandom};
        else
          in_digest = pool[$urandom_range(0, 3)];
        in_tag = $urandom;
        clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      cfg_we = 0; in_valid = 0; clr = 0;
      tick();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_md5_match_unit
